uart_tx_fifo: RTL

//  Buffered UART transmitter that receives the CPU's byte stores to UART_ADDR and drives the serial line.
//  - Input: the Memory Access stage's uart_we / data_in[7:0] pair.
//  - Bytes queue in a FIFO, so back-to-back stores never stall the single-cycle core.
//  - Bytes are serialised 8N1, LSB first, at CLKS_PER_BIT clocks per bit.
//  - Exposes full/empty/count and an overflow flag, readable by software via a status mapping.

---
 rtl/uart_tx_fifo.sv | 94 +++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 LSB-first UART transmitter.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              ovf_clr,
  output logic              tx,
  output logic              tx_busy,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state_q;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_q, rd_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, tx_q;
  logic [7:0]        shift_q;
  logic [2:0]        bit_q;
  logic [15:0]       baud_q;
  logic              push, pop, baud_done;
  assign fifo_full  = count_q == (ADDR_W+1)'(FIFO_DEPTH);
  assign fifo_empty = count_q == '0;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign tx         = tx_q;
  assign tx_busy    = state_q != IDLE;
  assign push       = wr_en && !fifo_full;
  assign pop        = state_q == IDLE && !fifo_empty;
  assign baud_done  = baud_q == 16'(CLKS_PER_BIT - 1);
  assign count_d    = count_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= wr_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_q <= wr_q + ADDR_W'(1);
      if (pop) rd_q <= rd_q + ADDR_W'(1);
      // a rejected push takes priority over a clear in the same cycle
      ovf_q <= (wr_en && fifo_full) ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      shift_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          shift_q <= mem_q[rd_q];
          state_q <= START;
          tx_q    <= 1'b0;
          baud_q  <= '0;
        end
        START: if (baud_done) begin
          baud_q  <= '0;
          state_q <= DATA;
          tx_q    <= shift_q[0];
          bit_q   <= '0;
        end else baud_q <= baud_q + 16'd1;
        DATA: if (baud_done) begin
          baud_q <= '0;
          if (bit_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            shift_q <= shift_q >> 1;
            tx_q    <= shift_q[1];
            bit_q   <= bit_q + 3'd1;
          end
        end else baud_q <= baud_q + 16'd1;
        default: if (baud_done) begin
          baud_q  <= '0;
          state_q <= IDLE;
        end else baud_q <= baud_q + 16'd1;
      endcase
    end
  end
endmodule
